// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: mode control, three requesters and the RAM port.
// The arbiter takes the slave view; the environment (CPU, loader, RAM) takes master.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 12
);
   logic                  load_mode;
   logic                  busy;

   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_gnt;
   logic                  i_rvalid;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [31:0]           d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;

   logic                  l_req;
   logic                  l_we;
   logic [ADDR_WIDTH-1:0] l_addr;
   logic [31:0]           l_wdata;
   logic                  l_gnt;
   logic                  l_rvalid;

   logic [31:0]           rdata;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   modport slave (
      input  load_mode,
      input  i_req, i_addr,
      input  d_req, d_we, d_addr, d_wdata,
      input  l_req, l_we, l_addr, l_wdata,
      input  mem_rdata,
      output busy,
      output i_gnt, i_rvalid,
      output d_gnt, d_rvalid,
      output l_gnt, l_rvalid,
      output rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output load_mode,
      output i_req, i_addr,
      output d_req, d_we, d_addr, d_wdata,
      output l_req, l_we, l_addr, l_wdata,
      output mem_rdata,
      input  busy,
      input  i_gnt, i_rvalid,
      input  d_gnt, d_rvalid,
      input  l_gnt, l_rvalid,
      input  rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter for the shared word memory: round-robin fetch/data in run mode,
// loader-only in load mode, with read draining before each ownership hand-over.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned MEM_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StRun, StDrain, StLoad, StExit} state_e;
   typedef enum logic [1:0] {OwnI, OwnD, OwnL} owner_e;

   localparam int unsigned Depth = MEM_LAT + 1;

   state_e                state_q, state_d;
   logic                  last_d_q, last_d_d;
   logic [Depth-1:0]      tag_vld_q, tag_vld_d;
   owner_e                tag_own_q [Depth];
   logic                  mem_en_q, mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [31:0]           mem_wdata_q;

   logic                  i_gnt, d_gnt, l_gnt, any_gnt, reads_pending;
   logic                  gnt_we;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [31:0]           gnt_wdata;
   owner_e                gnt_own;

   assign reads_pending = |tag_vld_q;

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      l_gnt    = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StRun: begin
               // last_d_q set means D won most recently, so I takes the tie.
               if (bus.i_req && (!bus.d_req || last_d_q)) begin
                  i_gnt = 1'b1;
               end else if (bus.d_req) begin
                  d_gnt = 1'b1;
               end
               if (bus.load_mode) state_d = StDrain;
            end
            StDrain: begin
               if (!reads_pending) state_d = StLoad;
            end
            StLoad: begin
               if (!bus.load_mode) state_d = StExit;
               else                l_gnt   = bus.l_req;
            end
            StExit: begin
               if (!reads_pending) begin
                  state_d  = StRun;
                  last_d_d = 1'b1;
               end
            end
            default: state_d = StRun;
         endcase
         if (i_gnt) last_d_d = 1'b0;
         if (d_gnt) last_d_d = 1'b1;
      end
   end

   always_comb begin
      gnt_we    = 1'b0;
      gnt_addr  = bus.i_addr;
      gnt_wdata = '0;
      gnt_own   = OwnI;
      if (d_gnt) begin
         gnt_we    = bus.d_we;
         gnt_addr  = bus.d_addr;
         gnt_wdata = bus.d_wdata;
         gnt_own   = OwnD;
      end else if (l_gnt) begin
         gnt_we    = bus.l_we;
         gnt_addr  = bus.l_addr;
         gnt_wdata = bus.l_wdata;
         gnt_own   = OwnL;
      end
   end

   assign any_gnt   = i_gnt | d_gnt | l_gnt;
   assign tag_vld_d = {tag_vld_q[Depth-2:0], any_gnt & ~gnt_we};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         last_d_q    <= 1'b1;
         tag_vld_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         for (int i = 0; i < Depth; i++) tag_own_q[i] <= OwnI;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         tag_vld_q <= tag_vld_d;
         mem_en_q  <= any_gnt;
         mem_we_q  <= any_gnt & gnt_we;
         if (any_gnt) begin
            mem_addr_q  <= gnt_addr;
            mem_wdata_q <= gnt_wdata;
         end
         tag_own_q[0] <= gnt_own;
         for (int i = 1; i < Depth; i++) tag_own_q[i] <= tag_own_q[i-1];
      end
   end

   assign bus.i_gnt     = i_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.l_gnt     = l_gnt;
   assign bus.i_rvalid  = tag_vld_q[Depth-1] && (tag_own_q[Depth-1] == OwnI);
   assign bus.d_rvalid  = tag_vld_q[Depth-1] && (tag_own_q[Depth-1] == OwnD);
   assign bus.l_rvalid  = tag_vld_q[Depth-1] && (tag_own_q[Depth-1] == OwnL);
   assign bus.rdata     = tag_vld_q[Depth-1] ? bus.mem_rdata : '0;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = (state_q != StRun);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, every cycle checked
// against a transaction-level model (mode, tie-break owner, queue of owed read returns).
module tb_mem_port_arbiter;
   localparam int unsigned AW  = 12;
   localparam int unsigned LAT = 2;
   localparam int MRun = 0, MDrain = 1, MLoad = 2, MExit = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] init_word(input logic [AW-1:0] a);
      return {20'hC0DE5, a};
   endfunction

   // RAM environment: read data appears LAT cycles after the enable cycle.
   logic [31:0] ram     [1<<AW];
   bit          ram_wr  [1<<AW];
   logic [31:0] rd_pipe [LAT];
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         ram[bus.mem_addr]    <= bus.mem_wdata;
         ram_wr[bus.mem_addr] <= 1'b1;
      end
      if (bus.mem_en && !bus.mem_we)
         rd_pipe[0] <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_word(bus.mem_addr);
      else
         rd_pipe[0] <= 'x;
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign bus.mem_rdata = rd_pipe[LAT-1];

   typedef struct {
      int          due;
      int          owner;
      logic [31:0] data;
   } ret_t;

   ret_t          pend [$];
   logic [31:0]   shadow    [1<<AW];
   bit            shadow_wr [1<<AW];
   int            mode, last_owner, cyc, g;
   int            checks, errors;
   logic          exp_en, exp_we;
   logic [AW-1:0] exp_addr;
   logic [31:0]   exp_wdata;
   bit            i_keep, d_keep, l_keep;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] shadow_rd(input logic [AW-1:0] a);
      return shadow_wr[a] ? shadow[a] : init_word(a);
   endfunction

   task automatic model_reset();
      pend.delete();
      mode       = MRun;
      last_owner = 1;
      exp_en     = 1'b0;
      exp_we     = 1'b0;
      exp_addr   = '0;
      exp_wdata  = '0;
   endtask

   task automatic tick();
      logic [2:0]    eg, erv;
      logic [31:0]   erd, wd;
      logic          we;
      logic [AW-1:0] a;
      @(negedge clk);
      g = -1;
      if (rst) begin
         model_reset();
      end else begin
         erv = '0;
         erd = '0;
         if (pend.size() != 0 && pend[0].due == cyc) begin
            erv[2-pend[0].owner] = 1'b1;
            erd = pend[0].data;
         end
         if (mode == MRun) begin
            if (bus.i_req && bus.d_req) g = (last_owner == 0) ? 1 : 0;
            else if (bus.i_req)         g = 0;
            else if (bus.d_req)         g = 1;
         end else if (mode == MLoad && bus.load_mode && bus.l_req) begin
            g = 2;
         end
         eg = '0;
         if (g >= 0) eg[2-g] = 1'b1;
         chk("gnt", {bus.i_gnt, bus.d_gnt, bus.l_gnt}, eg);
         chk("rvalid", {bus.i_rvalid, bus.d_rvalid, bus.l_rvalid}, erv);
         chk("rdata", bus.rdata, erd);
         chk("mem_cmd", {bus.mem_en, bus.mem_we}, {exp_en, exp_we});
         chk("mem_addr", bus.mem_addr, exp_addr);
         if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
         chk("busy", bus.busy, mode != MRun);
         if (g == 0 || g == 1) last_owner = g;
         // Owed reads include one being returned this very cycle.
         case (mode)
            MRun:    if (bus.load_mode) mode = MDrain;
            MDrain:  if (pend.size() == 0) mode = MLoad;
            MLoad:   if (!bus.load_mode) mode = MExit;
            default: if (pend.size() == 0) begin mode = MRun; last_owner = 1; end
         endcase
         if (erv != 0) void'(pend.pop_front());
         exp_en = (g >= 0);
         exp_we = 1'b0;
         if (g >= 0) begin
            we = 1'b0; a = bus.i_addr; wd = '0;
            if (g == 1) begin we = bus.d_we; a = bus.d_addr; wd = bus.d_wdata; end
            if (g == 2) begin we = bus.l_we; a = bus.l_addr; wd = bus.l_wdata; end
            exp_we   = we;
            exp_addr = a;
            if (we) begin
               exp_wdata    = wd;
               shadow[a]    = wd;
               shadow_wr[a] = 1'b1;
            end else begin
               pend.push_back('{due: cyc + 1 + LAT, owner: g, data: shadow_rd(a)});
            end
         end
      end
      @(posedge clk);
      #1;
      if (g == 0 && !i_keep) bus.i_req = 1'b0;
      if (g == 1 && !d_keep) bus.d_req = 1'b0;
      if (g == 2 && !l_keep) bus.l_req = 1'b0;
      cyc++;
   endtask

   task automatic req_i(input logic [AW-1:0] a);
      bus.i_req = 1'b1; bus.i_addr = a;
   endtask
   task automatic req_d(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
   endtask
   task automatic req_l(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
      bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = a; bus.l_wdata = wd;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk(tag, {bus.i_gnt, bus.d_gnt, bus.l_gnt, bus.i_rvalid, bus.d_rvalid, bus.l_rvalid,
                bus.mem_en, bus.mem_we, bus.busy}, '0);
      chk({tag, "_addr"}, bus.mem_addr, '0);
      chk({tag, "_wdata"}, bus.mem_wdata, '0);
      chk({tag, "_rdata"}, bus.rdata, '0);
   endtask

   initial begin
      bit seen;
      rst = 1'b1;
      bus.load_mode = 1'b0;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
      i_keep = 0; d_keep = 0; l_keep = 0;
      cyc = 0; checks = 0; errors = 0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      chk_reset_outputs("reset");

      // Both CPU ports requesting continuously: I,D,I,D.
      i_keep = 1; d_keep = 1;
      req_i(12'h010);
      req_d(1'b0, 12'h020, '0);
      repeat (4) tick();
      i_keep = 0; d_keep = 0;
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      repeat (4) tick();

      // Data write then read-back.
      req_d(1'b1, 12'h005, 32'hDEADBEEF);
      tick();
      req_d(1'b0, 12'h005, '0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.d_rvalid) begin
            seen = 1;
            chk("d_read_back", bus.rdata, 32'hDEADBEEF);
         end
         tick();
      end
      chk("d_read_seen", seen, 1'b1);

      // Enter load mode right after a fetch grant; loader waits out the drain.
      req_i(12'h033);
      tick();
      bus.load_mode = 1'b1;
      req_l(1'b1, 12'h000, 32'h1111_0000);
      for (int k = 0; k < 12 && bus.l_req; k++) tick();
      chk("load_entered", bus.l_req, 1'b0);

      // Loader streaming with CPU ports held off, then exit and I wins the tie.
      req_i(12'h040);
      req_d(1'b0, 12'h041, '0);
      for (int a = 1; a < 4; a++) begin
         req_l(1'b1, AW'(a), $urandom);
         tick();
      end
      req_l(1'b0, 12'h002, '0);
      tick();
      repeat (2) tick();
      bus.load_mode = 1'b0;
      repeat (10) tick();
      chk("cpu_served", {bus.i_req, bus.d_req}, 2'b00);

      // Reset with two reads outstanding.
      req_i(12'h010);
      req_d(1'b0, 12'h011, '0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_outputs("mid_reset");
      repeat (6) tick();

      // load_mode pulse during drain still walks DRAIN, LOAD, EXIT, RUN.
      req_i(12'h007);
      tick();
      bus.load_mode = 1'b1;
      tick();
      bus.load_mode = 1'b0;
      repeat (10) tick();
      chk("pulse_back_to_run", bus.busy, 1'b0);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         if (!bus.i_req && $urandom_range(2) == 0) req_i(AW'($urandom_range(15)));
         if (!bus.d_req && $urandom_range(2) == 0)
            req_d(1'($urandom_range(1)), AW'($urandom_range(15)), $urandom);
         if (!bus.l_req && $urandom_range(2) == 0)
            req_l(1'($urandom_range(1)), AW'($urandom_range(15)), $urandom);
         if ($urandom_range(39) == 0) bus.load_mode = ~bus.load_mode;
         rst = ($urandom_range(299) == 0);
         tick();
      end
      rst = 1'b0;
      bus.load_mode = 1'b0;
      bus.l_req = 1'b0;
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port arbiter and mode sequencer for the shared word memory bank. It multiplexes three requesters onto one synchronous RAM port: CPU instruction fetch (I), CPU data access (D), and the byte-to-word program loader (L). It sits between the CPU and loader on one side and the memory bank on the other. It switches cleanly between run mode and program-load mode by draining in-flight reads before handing the port over.

## Interface
- ADDR_WIDTH, 12, word address width
- MEM_LAT, 1, RAM read latency in cycles from registered enable to valid mem_rdata (1..4)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_mode  in  1  level; 1 requests loader-owned mode
- i_req, i_addr  in  1, ADDR_WIDTH  fetch request (read only)
- i_gnt, i_rvalid  out  1, 1  fetch accepted / fetch data valid
- d_req, d_we, d_addr, d_wdata  in  1, 1, ADDR_WIDTH, 32  data request
- d_gnt, d_rvalid  out  1, 1
- l_req, l_we, l_addr, l_wdata  in  1, 1, ADDR_WIDTH, 32  loader request
- l_gnt, l_rvalid  out  1, 1
- rdata  out  32  shared read data, valid only with an *_rvalid
- mem_en, mem_we  out  1, 1  registered RAM enable / write
- mem_addr, mem_wdata  out  ADDR_WIDTH, 32  registered RAM address / write data
- mem_rdata  in  32  RAM read data
- busy  out  1  high whenever state is not RUN

## Operation
- Request rules:
  - A requester holds req, we, addr and wdata stable until its gnt.
  - gnt is combinational in the cycle it is granted.
  - At most one gnt per cycle.
- FSM states: RUN, DRAIN, LOAD, EXIT. Reset state is RUN.
- RUN:
  - Arbitrates I and D only; L is never granted.
  - A single requester is granted.
  - When both request, the one not granted most recently wins.
  - The round-robin pointer updates only on a grant. Reset sets last=D, so I wins the first tie.
  - load_mode=1 moves to DRAIN the next cycle. The grant decision in that cycle is still made normally.
- DRAIN: no grants. Moves to LOAD in the cycle after the outstanding-read count reaches 0.
- LOAD:
  - Only L is granted, every cycle it requests.
  - load_mode=0 moves to EXIT. No L grant is issued in the cycle load_mode is sampled low.
- EXIT: no grants. When outstanding reads reach 0, moves to RUN and resets the pointer to last=D.
- Memory command:
  - A grant in cycle t registers mem_en=1, mem_we=we, mem_addr and mem_wdata in cycle t+1.
  - With no grant, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their previous values.
- Read return:
  - Each granted read pushes an owner tag into a MEM_LAT+1 deep valid/owner pipeline.
  - At t+1+MEM_LAT the owner's *_rvalid pulses for one cycle, with rdata=mem_rdata passed through.
  - Writes push an invalid tag and produce no rvalid.
- Outstanding-read count = number of valid tags in the pipeline. Range 0..MEM_LAT+1; it never overflows because at most one push occurs per cycle.
- Simultaneous events:
  - A load_mode toggle during DRAIN or EXIT is honoured only after the drain completes. DRAIN always goes to LOAD. EXIT always goes to RUN; if load_mode=1 then, RUN moves to DRAIN the next cycle.
  - A req deasserted before gnt is illegal and need not be handled.

## Timing
- Grant-to-mem_en latency: 1 cycle.
- Grant-to-rvalid latency for reads: 1+MEM_LAT cycles.
- Throughput: 1 access per cycle.
- Mode switch costs the drain time plus 1 cycle (min 1 cycle when idle).
- Reset values: all gnt=0, all rvalid=0, rdata=0 (combinationally gated by rvalid), mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, pipeline tags cleared, state=RUN.
- Reset mid-operation: in-flight reads are discarded and no rvalid follows reset. rst dominates load_mode.

## Test plan
- After reset, i_req=1 and d_req=1 held with addrs 0x010 and 0x020, MEM_LAT=1 → gnt sequence I,D,I,D. mem_addr 0x010 at cycle 1. i_rvalid at cycle 2 with rdata=RAM[0x010].
- D write: d_we=1, addr 0x005, data 0xDEADBEEF → mem_en=mem_we=1 next cycle. No d_rvalid. A later D read of 0x005 returns 0xDEADBEEF.
- Raise load_mode one cycle after an I read grant (MEM_LAT=2) → busy=1. No grants until i_rvalid is delivered. First l_gnt comes in the cycle after the count hits 0.
- In LOAD, l_req/l_we streaming addrs 0..3 → four consecutive l_gnt. i_req and d_req stay ungranted. Dropping load_mode → EXIT, then RUN, and I wins the first tie.
- rst asserted while two reads are outstanding (MEM_LAT=2) → no rvalid afterwards. All outputs are at their reset values in the cycle after rst.
- load_mode pulsed high then low during DRAIN → still enters LOAD, then EXIT, then RUN. Every granted read returns exactly one rvalid to its owner.
